// File: rtl/tlc_phase_scheduler_if.sv
// Request/lamp bundle for tlc_phase_scheduler.
// Defining TLC_PED_EN adds the pedestrian PED request and WALK lamp.
interface tlc_phase_scheduler_if;
  logic       FM;
  logic       TEST;
  logic       REQ1;
  logic       REQ2;
  logic       GRN1;
  logic       YLW1;
  logic       RED1;
  logic       GRN2;
  logic       YLW2;
  logic       RED2;
  logic [2:0] PHASE;
`ifdef TLC_PED_EN
  logic       PED;
  logic       WALK;
`endif

  // master: intersection side (sensors, mode switches); slave: the scheduler
  modport master (
`ifdef TLC_PED_EN
    output PED,
    input  WALK,
`endif
    output FM, TEST, REQ1, REQ2,
    input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, PHASE
  );

  modport slave (
`ifdef TLC_PED_EN
    input  PED,
    output WALK,
`endif
    input  FM, TEST, REQ1, REQ2,
    output GRN1, YLW1, RED1, GRN2, YLW2, RED2, PHASE
  );
endinterface

// File: rtl/tlc_phase_scheduler.sv
// Two-road traffic-light phase scheduler: G -> Y -> all-red per road, min/max green arbitration.
// Optional pedestrian extension of the all-red phase is enabled with `define TLC_PED_EN.
module tlc_phase_scheduler #(
  parameter int CW       = 6,
  parameter int GMIN     = 8,
  parameter int GMAX     = 32,
  parameter int YLW_T    = 4,
  parameter int ALLRED_T = 2
`ifdef TLC_PED_EN
  ,
  parameter int PED_T    = 6
`endif
) (
  input  logic                  CK,
  input  logic                  CLR,
  tlc_phase_scheduler_if.slave  bus
);

  // Two extra bits so durations of 2^CW and all-red+walk sums fit
  localparam int DW = CW + 2;
  typedef logic [DW-1:0] dur_t;

  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    G2  = 3'd3,
    Y2  = 3'd4,
    AR2 = 3'd5
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic          pend1_reg, pend1_next;
  logic          pend2_reg, pend2_next;
  logic [5:0]    lamp_reg, lamp_next;
  logic          state_change;

  dur_t gmin_eff, gmax_eff, ylw_eff, allred_eff, clear_eff, elapsed;

  function automatic dur_t eff_dur(input int d, input logic fm, input logic test);
    dur_t full;
    dur_t quarter;
    full    = dur_t'(d);
    quarter = full >> 2;
    if (test)
      eff_dur = dur_t'(1);
    else if (fm)
      eff_dur = (quarter == '0) ? dur_t'(1) : quarter;
    else
      eff_dur = full;
  endfunction

  // Lamp order {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      G1:      lamps_of = 6'b100_001;
      Y1:      lamps_of = 6'b010_001;
      G2:      lamps_of = 6'b001_100;
      Y2:      lamps_of = 6'b001_010;
      default: lamps_of = 6'b001_001;
    endcase
  endfunction

  assign gmin_eff   = eff_dur(GMIN, bus.FM, bus.TEST);
  assign gmax_eff   = eff_dur(GMAX, bus.FM, bus.TEST);
  assign ylw_eff    = eff_dur(YLW_T, bus.FM, bus.TEST);
  assign allred_eff = eff_dur(ALLRED_T, bus.FM, bus.TEST);

  // Cycles spent in the state including this one; ">=" keeps a phase from
  // sticking if FM/TEST shorten the duration after the timer has passed it.
  assign elapsed = dur_t'(timer_reg) + dur_t'(1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      G1: begin
        if (bus.TEST || (pend2_reg && (bus.REQ1 ? (elapsed >= gmax_eff)
                                                : (elapsed >= gmin_eff))))
          state_next = Y1;
      end
      Y1:  if (elapsed >= ylw_eff)   state_next = AR1;
      AR1: if (elapsed >= clear_eff) state_next = G2;
      G2: begin
        if (bus.TEST || (pend1_reg && (bus.REQ2 ? (elapsed >= gmax_eff)
                                                : (elapsed >= gmin_eff))))
          state_next = Y2;
      end
      Y2:  if (elapsed >= ylw_eff)   state_next = AR2;
      AR2: if (elapsed >= clear_eff) state_next = G1;
      default: state_next = AR2;
    endcase
  end

  assign state_change = (state_next != state_reg);

  always_comb begin
    timer_next = timer_reg;
    if (state_change)
      timer_next = '0;
    else if (timer_reg != '1)
      timer_next = timer_reg + CW'(1);

    // Entry into a green serves that road, so the clear beats a same-edge request
    pend1_next = (state_change && state_next == G1) ? 1'b0 : (pend1_reg | bus.REQ1);
    pend2_next = (state_change && state_next == G2) ? 1'b0 : (pend2_reg | bus.REQ2);
    lamp_next  = lamps_of(state_next);
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state_reg <= AR2;
      timer_reg <= '0;
      pend1_reg <= 1'b0;
      pend2_reg <= 1'b0;
      lamp_reg  <= 6'b001_001;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      pend1_reg <= pend1_next;
      pend2_reg <= pend2_next;
      lamp_reg  <= lamp_next;
    end
  end

`ifdef TLC_PED_EN
  logic ped_pend_reg, ped_pend_next;
  logic ped_ext_reg, ped_ext_next;
  logic walk_reg, walk_next;
  dur_t ped_eff;

  assign ped_eff   = eff_dur(PED_T, bus.FM, bus.TEST);
  assign clear_eff = allred_eff + (ped_ext_reg ? ped_eff : dur_t'(0));

  always_comb begin
    ped_ext_next = ped_ext_reg;
    // Extension is decided once, on entry into an all-red phase
    if (state_change)
      ped_ext_next = ped_pend_reg && (state_next == AR1 || state_next == AR2);
    walk_next     = ped_ext_next && (dur_t'(timer_next) >= allred_eff);
    ped_pend_next = (walk_next && !walk_reg) ? 1'b0 : (ped_pend_reg | bus.PED);
  end

  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      ped_pend_reg <= 1'b0;
      ped_ext_reg  <= 1'b0;
      walk_reg     <= 1'b0;
    end else begin
      ped_pend_reg <= ped_pend_next;
      ped_ext_reg  <= ped_ext_next;
      walk_reg     <= walk_next;
    end
  end

  assign bus.WALK = walk_reg;
`else
  assign clear_eff = allred_eff;
`endif

  assign bus.PHASE = state_reg;
  assign {bus.GRN1, bus.YLW1, bus.RED1, bus.GRN2, bus.YLW2, bus.RED2} = lamp_reg;

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
- Two-road traffic-light phase scheduler: arbitrates green time between road 1 and road 2 from vehicle-sensor requests, sequences green → yellow → all-red clearance, drives the six lamp outputs.
- Timed phase controller for the intersection's lamp datapath. Adds latched requests, min/max green arbitration, fast mode (FM) and a test-step mode (TEST).

Parameters:
- CW, 6, phase timer width in bits; every duration parameter must be ≤ 2^CW.
- GMIN, 8, minimum green cycles when the other road is waiting.
- GMAX, 32, maximum green cycles when both roads demand.
- YLW_T, 4, yellow duration in cycles.
- ALLRED_T, 2, all-red clearance duration in cycles.

Ports:
- CK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- FM  in  1  fast mode: all durations shortened
- TEST  in  1  test-step mode: every phase lasts 1 cycle
- REQ1  in  1  road-1 vehicle sensor
- REQ2  in  1  road-2 vehicle sensor
- GRN1, YLW1, RED1  out  1 each  road-1 lamps
- GRN2, YLW2, RED2  out  1 each  road-2 lamps
- PHASE  out  3  current state code

Behaviour:
- Interface fixed: one clock CK; reset CLR is asynchronous and active-high.
- States and PHASE codes: G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5. Codes 6 and 7 are illegal and recover to AR2 on the next edge.
- Lamps are Moore outputs, registered together with the state. Per road exactly one of GRN/YLW/RED is high.
  - G1: GRN1, RED2.
  - Y1: YLW1, RED2.
  - AR1, AR2: RED1, RED2.
  - G2: RED1, GRN2.
  - Y2: RED1, YLW2.
- Reset: CLR high asynchronously forces state AR2, timer 0 and both pend flags 0. Outputs go immediately to RED1=RED2=1 with all others 0, PHASE=5. This applies mid-phase as well.
- Timer:
  - Counts cycles spent in the current state.
  - Cleared on every state change; held at saturation, never wraps.
  - A state of duration d is left on the edge where timer == d-1, so it occupies exactly d cycles.
- Effective duration d_eff:
  - FM=0: d.
  - FM=1: max(1, d>>2).
  - TEST=1: 1 for every state, overriding FM. Requests are ignored and the machine loops G1→Y1→AR1→G2→Y2→AR2, 6 cycles per loop.
  - FM and TEST are sampled every cycle.
- Request latching:
  - pend2 is set on any edge where REQ2=1; cleared on entry to G2.
  - pend1 is set on any edge where REQ1=1; cleared on entry to G1.
  - A set and a clear on the same edge: the clear wins, because the request is being served.
  - Latency: a request asserted in cycle k can affect the transition decision from cycle k+1.
- G1 exit to Y1:
  - pend2=1, REQ1=0 and timer ≥ GMIN_eff-1 → exit.
  - pend2=1, REQ1=1 (both demanding) → stay until timer == GMAX_eff-1, then exit.
  - pend2=0 → stay indefinitely; the timer saturates.
- G2 is symmetric with roads swapped.
- Y1→AR1 after YLW_T_eff; AR1→G2 after ALLRED_T_eff. Y2→AR2 and AR2→G1 likewise.
- After reset release: AR2 for ALLRED_T_eff cycles, then G1.

Optional Feature:
- Macro TLC_PED_EN adds input PED (1), output WALK (1) and parameter PED_T (default 6).
- With TLC_PED_EN:
  - PED sets ped_pend.
  - On the next entry to AR1 or AR2 while ped_pend=1, the all-red phase lasts ALLRED_T_eff + PED_T_eff cycles.
  - WALK=1 during the final PED_T_eff of those cycles.
  - ped_pend clears when WALK first rises.
  - CLR clears ped_pend and WALK.
- Without TLC_PED_EN: the ports, parameter and logic are absent, and behaviour is exactly as above.

Test Plan:
- Reset release, FM=TEST=0, REQ1=REQ2=0 → PHASE=5 for 2 cycles, then PHASE=0 (GRN1=1, RED2=1) held for 100+ cycles.
- In G1, REQ2 pulsed 1 cycle, REQ1=0 → G1 lasts 8 cycles total, Y1 4 cycles, AR1 2 cycles, then G2 (GRN2=1); pend2 reads 0 in G2.
- REQ1=REQ2=1 held → G1 lasts 32 cycles, Y1 4, AR1 2, G2 32, Y2 4, AR2 2; repeats with period 76.
- FM=1, REQ1=0, REQ2=1 → G1 2 cycles, Y1 1, AR1 1 (0 clamped to 1).
- TEST=1 → PHASE sequence 0,1,2,3,4,5,0…, one cycle each, regardless of REQ inputs.
- CLR asserted asynchronously mid-Y1 (between edges) → RED1=RED2=1, PHASE=5 before the next CK edge. After release: 2 cycles AR2, then G1.
